// File: rtl/svm_pkg.sv
// rtl/svm_pkg.sv - shared types and constants for the SVM dot-product sequencer
package svm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_OUTPUT,
        ST_DONE
    } svm_state_e;

    localparam int MEM_LAT     = 1;
    localparam int DP_LAT      = 1;
    localparam int DRAIN_DEPTH = MEM_LAT + DP_LAT;
    localparam int MAC_SCALE   = 4;

    function automatic int mac_width(input int xlen);
        return MAC_SCALE * xlen;
    endfunction

endpackage

// File: rtl/svm_addr_gen.sv
// rtl/svm_addr_gen.sv - pixel/SV counters and memory address registers for one pass
module svm_addr_gen import svm_pkg::*; #(
    parameter int NUM_OF_PIXELS = 30,
    parameter int NUM_SV        = 16,
    parameter int TADDR_W       = 5,
    parameter int SADDR_W       = 9,
    parameter int SVIDX_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pass_init_i,
    input  logic               sv_load_i,
    input  logic               pix_step_i,
    input  logic               sv_next_i,
    output logic [TADDR_W-1:0] test_addr_o,
    output logic [SADDR_W-1:0] sv_addr_o,
    output logic [SVIDX_W-1:0] sv_idx_o,
    output logic               last_pix_o,
    output logic               last_sv_o
);

    logic [TADDR_W-1:0] pix_q, pix_d;
    logic [SVIDX_W-1:0] sv_idx_q, sv_idx_d;
    logic [SADDR_W-1:0] base_q, base_d;
    logic [TADDR_W-1:0] taddr_q, taddr_d;
    logic [SADDR_W-1:0] saddr_q, saddr_d;

    assign last_pix_o  = (pix_q == TADDR_W'(NUM_OF_PIXELS - 1));
    assign last_sv_o   = (sv_idx_q == SVIDX_W'(NUM_SV - 1));
    assign test_addr_o = taddr_q;
    assign sv_addr_o   = saddr_q;
    assign sv_idx_o    = sv_idx_q;

    always_comb begin
        pix_d    = pix_q;
        sv_idx_d = sv_idx_q;
        base_d   = base_q;
        taddr_d  = taddr_q;
        saddr_d  = saddr_q;
        if (pass_init_i) begin
            sv_idx_d = '0;
            base_d   = '0;
        end else if (sv_next_i) begin
            sv_idx_d = sv_idx_q + 1'b1;
            base_d   = base_q + SADDR_W'(NUM_OF_PIXELS);
        end
        // Address registers lead the pixel counter by one load so they stay
        // on the last issued address once streaming stops.
        if (sv_load_i) begin
            pix_d   = '0;
            taddr_d = '0;
            saddr_d = base_q;
        end else if (pix_step_i) begin
            if (last_pix_o) begin
                pix_d = '0;
            end else begin
                pix_d   = pix_q + 1'b1;
                taddr_d = pix_q + 1'b1;
                saddr_d = saddr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q    <= '0;
            sv_idx_q <= '0;
            base_q   <= '0;
            taddr_q  <= '0;
            saddr_q  <= '0;
        end else begin
            pix_q    <= pix_d;
            sv_idx_q <= sv_idx_d;
            base_q   <= base_d;
            taddr_q  <= taddr_d;
            saddr_q  <= saddr_d;
        end
    end

endmodule

// File: rtl/svm_dot_sched.sv
// rtl/svm_dot_sched.sv - sequences test/SV pixel pairs into dot_prod and returns one result per SV
module svm_dot_sched import svm_pkg::*; #(
    parameter int XLEN_PIXEL    = 8,
    parameter int NUM_OF_PIXELS = 30,
    parameter int NUM_SV        = 16,
    parameter int TADDR_W       = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1,
    parameter int SADDR_W       = (NUM_SV * NUM_OF_PIXELS > 1) ? $clog2(NUM_SV * NUM_OF_PIXELS) : 1,
    parameter int SVIDX_W       = (NUM_SV > 1) ? $clog2(NUM_SV) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic [TADDR_W-1:0]                  test_addr,
    input  logic [XLEN_PIXEL-1:0]               test_data,
    output logic [SADDR_W-1:0]                  sv_addr,
    input  logic [XLEN_PIXEL-1:0]               sv_data,
    output logic                                dp_rst,
    output logic [XLEN_PIXEL-1:0]               dp_x_test,
    output logic [XLEN_PIXEL-1:0]               dp_x_sv,
    input  logic [mac_width(XLEN_PIXEL)-1:0]    dp_mac_out,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [SVIDX_W-1:0]                  res_sv_idx,
    output logic [mac_width(XLEN_PIXEL)-1:0]    res_data
);

    localparam int MAC_W = mac_width(XLEN_PIXEL);

    svm_state_e         state_q, state_d;
    logic [1:0]         drain_q, drain_d;
    logic               rd_valid_q;
    logic [MAC_W-1:0]   res_data_q;
    logic [SVIDX_W-1:0] res_idx_q;

    logic               pass_init, sv_load, pix_step, sv_next, res_capture;
    logic               last_pix, last_sv;
    logic [SVIDX_W-1:0] sv_idx;

    svm_addr_gen #(
        .NUM_OF_PIXELS (NUM_OF_PIXELS),
        .NUM_SV        (NUM_SV),
        .TADDR_W       (TADDR_W),
        .SADDR_W       (SADDR_W),
        .SVIDX_W       (SVIDX_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .pass_init_i (pass_init),
        .sv_load_i   (sv_load),
        .pix_step_i  (pix_step),
        .sv_next_i   (sv_next),
        .test_addr_o (test_addr),
        .sv_addr_o   (sv_addr),
        .sv_idx_o    (sv_idx),
        .last_pix_o  (last_pix),
        .last_sv_o   (last_sv)
    );

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        pass_init   = 1'b0;
        sv_load     = 1'b0;
        pix_step    = 1'b0;
        sv_next     = 1'b0;
        res_capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pass_init = 1'b1;
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                sv_load = 1'b1;
                drain_d = '0;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                pix_step = 1'b1;
                if (last_pix) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The last operand pair reaches dp_mac_out only after both the
                // memory and accumulator registers have been passed.
                if (drain_q == 2'(DRAIN_DEPTH - 1)) begin
                    res_capture = 1'b1;
                    state_d     = ST_OUTPUT;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            ST_OUTPUT: begin
                if (res_ready) begin
                    if (last_sv) begin
                        state_d = ST_DONE;
                    end else begin
                        sv_next = 1'b1;
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            drain_q    <= '0;
            rd_valid_q <= 1'b0;
            res_data_q <= '0;
            res_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            rd_valid_q <= (state_q == ST_STREAM);
            if (res_capture) begin
                res_data_q <= dp_mac_out;
                res_idx_q  <= sv_idx;
            end
        end
    end

    // Zero operands outside valid reads so idle and drain cycles add nothing.
    assign dp_x_test  = (rd_valid_q && !rst) ? test_data : '0;
    assign dp_x_sv    = (rd_valid_q && !rst) ? sv_data   : '0;
    assign dp_rst     = rst || (state_q == ST_CLEAR);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign res_valid  = (state_q == ST_OUTPUT);
    assign res_data   = res_data_q;
    assign res_sv_idx = res_idx_q;

endmodule

// File: tb/tb_svm_dot_sched.sv
// tb/tb_svm_dot_sched.sv - directed checks of svm_dot_sched with a behavioural dot_prod and memories
module tb_svm_dot_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- instance A: N=4, NUM_SV=1
    logic       start_a, busy_a, done_a, dprst_a, rv_a, ready_a;
    logic [1:0] taddr_a, saddr_a;
    logic [7:0] tdat_a, sdat_a, xt_a, xs_a;
    logic [31:0] mac_a, rd_a;
    logic [0:0] idx_a;
    logic [7:0] tmem_a [0:3];
    logic [7:0] smem_a [0:3];

    svm_dot_sched #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(4), .NUM_SV(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .test_addr(taddr_a), .test_data(tdat_a), .sv_addr(saddr_a), .sv_data(sdat_a),
        .dp_rst(dprst_a), .dp_x_test(xt_a), .dp_x_sv(xs_a), .dp_mac_out(mac_a),
        .res_valid(rv_a), .res_ready(ready_a), .res_sv_idx(idx_a), .res_data(rd_a));

    always @(posedge clk) begin
        tdat_a <= tmem_a[taddr_a];
        sdat_a <= smem_a[saddr_a];
        mac_a  <= dprst_a ? 32'd0 : mac_a + 32'(xt_a) * 32'(xs_a);
    end

    // ---------------- instance B: N=4, NUM_SV=3
    logic       start_b, busy_b, done_b, dprst_b, rv_b, ready_b;
    logic [1:0] taddr_b, idx_b;
    logic [3:0] saddr_b;
    logic [7:0] tdat_b, sdat_b, xt_b, xs_b;
    logic [31:0] mac_b, rd_b;
    logic [7:0] tmem_b [0:3];
    logic [7:0] smem_b [0:15];

    svm_dot_sched #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(4), .NUM_SV(3)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .test_addr(taddr_b), .test_data(tdat_b), .sv_addr(saddr_b), .sv_data(sdat_b),
        .dp_rst(dprst_b), .dp_x_test(xt_b), .dp_x_sv(xs_b), .dp_mac_out(mac_b),
        .res_valid(rv_b), .res_ready(ready_b), .res_sv_idx(idx_b), .res_data(rd_b));

    always @(posedge clk) begin
        tdat_b <= tmem_b[taddr_b];
        sdat_b <= smem_b[saddr_b];
        mac_b  <= dprst_b ? 32'd0 : mac_b + 32'(xt_b) * 32'(xs_b);
    end

    // ---------------- instance C: defaults N=30, NUM_SV=16
    logic       start_c, busy_c, done_c, dprst_c, rv_c, ready_c;
    logic [4:0] taddr_c;
    logic [8:0] saddr_c;
    logic [3:0] idx_c;
    logic [7:0] tdat_c, sdat_c, xt_c, xs_c;
    logic [31:0] mac_c, rd_c;
    logic [7:0] tmem_c [0:31];
    logic [7:0] smem_c [0:511];

    svm_dot_sched u_c (
        .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
        .test_addr(taddr_c), .test_data(tdat_c), .sv_addr(saddr_c), .sv_data(sdat_c),
        .dp_rst(dprst_c), .dp_x_test(xt_c), .dp_x_sv(xs_c), .dp_mac_out(mac_c),
        .res_valid(rv_c), .res_ready(ready_c), .res_sv_idx(idx_c), .res_data(rd_c));

    always @(posedge clk) begin
        tdat_c <= tmem_c[taddr_c];
        sdat_c <= smem_c[saddr_c];
        mac_c  <= dprst_c ? 32'd0 : mac_c + 32'(xt_c) * 32'(xs_c);
    end

    // Full default pass; optionally pokes start mid-STREAM of SV 0.
    task automatic run_pass_c(input bit poke);
        int s0, nres, first, done_at;
        @(negedge clk); start_c = 1'b1;
        @(negedge clk); start_c = 1'b0;
        s0 = cyc - 1; nres = 0; first = 0; done_at = 0;
        for (int i = 0; i < 700 && done_at == 0; i++) begin
            start_c = (poke && (cyc - s0 == 10));
            if (rv_c) begin
                if (first == 0) first = cyc - s0;
                check("c_data", rd_c, 1950750);
                check("c_idx", idx_c, nres);
                nres++;
            end
            if (done_c) done_at = cyc - s0;
            if (done_at == 0) @(negedge clk);
        end
        start_c = 1'b0;
        check("c_first_valid_cycle", first, 34);
        check("c_result_count", nres, 16);
        check("c_done_cycle", done_at, 545);
        @(negedge clk);
        check("c_busy_after_done", busy_c, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  s0, found, dcnt;
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        ready_a = 1'b1; ready_b = 1'b0; ready_c = 1'b1;
        tmem_a[0] = 8'd1; tmem_a[1] = 8'd2; tmem_a[2] = 8'd3; tmem_a[3] = 8'd4;
        smem_a[0] = 8'd5; smem_a[1] = 8'd6; smem_a[2] = 8'd7; smem_a[3] = 8'd8;
        for (int i = 0; i < 4; i++) tmem_b[i] = 8'd255;
        for (int i = 0; i < 16; i++) smem_b[i] = (i < 4) ? 8'd1 : (i < 8) ? 8'd0 : 8'd255;
        for (int i = 0; i < 32; i++) tmem_c[i] = 8'd255;
        for (int i = 0; i < 512; i++) smem_c[i] = 8'd255;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_dp_rst_high", dprst_c, 1);
        rst = 1'b0;
        #1;
        check("rst_busy", busy_c, 0);
        check("rst_done", done_c, 0);
        check("rst_res_valid", rv_c, 0);
        check("rst_dp_rst_low", dprst_c, 0);
        check("rst_x_test", xt_c, 0);
        check("rst_x_sv", xs_c, 0);
        check("rst_taddr", taddr_c, 0);
        check("rst_saddr", saddr_c, 0);
        check("rst_res_data", rd_c, 0);
        check("rst_res_idx", idx_c, 0);

        // single SV, N=4
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; s0 = cyc - 1;
        check("a_busy_c1", busy_a, 1);
        check("a_dp_rst_c1", dprst_a, 1);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (rv_a) found = 1; else @(negedge clk);
        end
        check("a_valid_seen", found, 1);
        check("a_valid_cycle", cyc - s0, 8);
        check("a_data", rd_a, 70);
        check("a_idx", idx_a, 0);
        @(negedge clk);
        check("a_done_c9", done_a, 1);
        check("a_busy_c9", busy_a, 1);
        @(negedge clk);
        check("a_busy_c10", busy_a, 0);
        check("a_done_c10", done_a, 0);

        // three SVs with backpressure on SV 0
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0; s0 = cyc - 1;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (rv_b) found = 1; else @(negedge clk);
        end
        check("b_valid0_seen", found, 1);
        check("b_valid0_cycle", cyc - s0, 8);
        check("b_data0", rd_b, 1020);
        check("b_idx0", idx_b, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b_hold_valid", rv_b, 1);
            check("b_hold_data", rd_b, 1020);
            check("b_hold_saddr", saddr_b, 3);
            check("b_hold_taddr", taddr_b, 3);
        end
        @(negedge clk); ready_b = 1'b1;
        check("b_accept_cycle", cyc - s0, 13);
        @(negedge clk);
        check("b_clear_after_accept", dprst_b, 1);
        check("b_valid_low_after_accept", rv_b, 0);
        repeat (7) @(negedge clk);
        check("b_valid1_cycle21", rv_b, 1);
        check("b_data1", rd_b, 0);
        check("b_idx1", idx_b, 1);
        repeat (8) @(negedge clk);
        check("b_valid2_cycle29", rv_b, 1);
        check("b_data2", rd_b, 260100);
        check("b_idx2", idx_b, 2);
        @(negedge clk);
        check("b_done_cycle30", done_b, 1);
        @(negedge clk);
        check("b_busy_cycle31", busy_b, 0);

        // defaults, all-max, with a stray start during STREAM
        run_pass_c(1'b1);

        // reset at pixel 10 of SV 2
        @(negedge clk); start_c = 1'b1;
        @(negedge clk); start_c = 1'b0; s0 = cyc - 1;
        while (cyc - s0 < 80) @(negedge clk);
        check("r_taddr_pix10", taddr_c, 10);
        check("r_saddr_pix10", saddr_c, 70);
        rst = 1'b1;
        #1;
        check("r_dp_rst_in_rst", dprst_c, 1);
        check("r_x_test_in_rst", xt_c, 0);
        @(negedge clk); rst = 1'b0;
        #1;
        check("r_busy", busy_c, 0);
        check("r_res_valid", rv_c, 0);
        check("r_done", done_c, 0);
        check("r_taddr", taddr_c, 0);
        check("r_saddr", saddr_c, 0);
        check("r_res_data", rd_c, 0);
        check("r_res_idx", idx_c, 0);
        check("r_x_sv", xs_c, 0);
        check("r_dp_rst", dprst_c, 0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_c || busy_c) dcnt++;
        end
        check("r_no_done_after_abort", dcnt, 0);
        run_pass_c(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
